// File: rtl/ssi_serial_engine.sv
// ---------------------------------------------------------------------------
// ssi_serial_engine
//
// Serial back-end of the APB SSI peripheral. Words written to DR are queued
// in a TX FIFO, shifted out MSB first as a Motorola-SPI master, and the
// simultaneously received bits are queued in a show-ahead RX FIFO for DR
// reads. Busy and FIFO status flags go back to the register block for SR.
//
// Ports
//   p_clk, p_resetn         system clock (rising edge), async active-low reset
//   cfg_dss/spo/sph         frame size select, SCLK polarity, SCLK phase
//   cfg_scr, cfg_cpsdvsr    serial clock rate and prescale divisor
//   cfg_sse, cfg_lbm        serial port enable, internal loopback
//   tx_wr_en/tx_wr_data     TX FIFO push (DR write)
//   rx_rd_en/rx_rd_data     RX FIFO pop (DR read); data is the head, 0 if empty
//   ssp_clk_out, ssp_fss_n  SCLK and active-low frame select
//   ssp_txd, ssp_rxd        serial data out / in
//   spi_bsy, spi_*_fifo_*   busy and FIFO status flags
// ---------------------------------------------------------------------------
module ssi_serial_engine #(
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_W      = 3,
   parameter int FRAME_W    = 16
) (
   input  logic               p_clk,
   input  logic               p_resetn,
   input  logic [3:0]         cfg_dss,
   input  logic               cfg_spo,
   input  logic               cfg_sph,
   input  logic [7:0]         cfg_scr,
   input  logic [7:0]         cfg_cpsdvsr,
   input  logic               cfg_sse,
   input  logic               cfg_lbm,
   input  logic               tx_wr_en,
   input  logic [FRAME_W-1:0] tx_wr_data,
   input  logic               rx_rd_en,
   output logic [FRAME_W-1:0] rx_rd_data,
   output logic               ssp_clk_out,
   output logic               ssp_fss_n,
   output logic               ssp_txd,
   input  logic               ssp_rxd,
   output logic               spi_bsy,
   output logic               spi_tx_fifo_empty,
   output logic               spi_tx_fifo_full,
   output logic               spi_rx_fifo_empty,
   output logic               spi_rx_fifo_full
);

   // NW bits hold a frame length up to FRAME_W; the edge counter needs one more.
   localparam int             NW       = $clog2(FRAME_W) + 1;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t               r_state;
   state_t               w_next;

   // FIFO storage and bookkeeping
   logic [FRAME_W-1:0]   r_tx_mem [FIFO_DEPTH];
   logic [FRAME_W-1:0]   r_rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [PTR_W:0]       r_tx_cnt, r_rx_cnt;

   // Per-frame configuration, frozen in LOAD
   logic [NW-1:0]        r_nbits;
   logic                 r_spo, r_sph, r_lbm;
   logic [15:0]          r_half;

   // Shift engine
   logic [15:0]          r_hcnt;
   logic [NW:0]          r_edge;
   logic [FRAME_W-1:0]   r_tx;
   logic [FRAME_W-1:0]   r_rx;
   logic                 r_sclk, r_fss_n, r_txd, r_bsy;

   logic                 w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic                 w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic                 w_load, w_gap_done;
   logic                 w_tick, w_last_edge, w_shift_edge, w_sample_edge;
   logic                 w_rx_bit;
   logic [NW-1:0]        w_nbits;
   logic [NW-1:0]        w_shamt;
   logic [FRAME_W-1:0]   w_aligned;
   logic [6:0]           w_presc;
   logic [15:0]          w_half;
   logic                 w_unused;

   // The divisor is even by definition; its LSB carries no information.
   assign w_unused = cfg_cpsdvsr[0];

   // ---------------- FIFO flags and handshakes ----------------
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == CNT_FULL);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == CNT_FULL);

   // Flags are judged on the pre-edge count, so a push into a full FIFO is
   // dropped even when a pop happens in the same cycle.
   assign w_tx_push  = tx_wr_en & ~w_tx_full;
   assign w_tx_pop   = w_load & ~w_tx_empty;
   assign w_rx_push  = w_gap_done & ~w_rx_full;
   assign w_rx_pop   = rx_rd_en & ~w_rx_empty;

   assign rx_rd_data = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];

   // ---------------- Live configuration decode ----------------
   assign w_nbits   = (cfg_dss < 4'd3) ? NW'(4) : NW'(cfg_dss) + NW'(1);
   assign w_shamt   = NW'(FRAME_W) - w_nbits;
   // Left-align the frame so the first bit to send sits in the MSB.
   assign w_aligned = r_tx_mem[r_tx_rp] << w_shamt;
   assign w_presc   = (cfg_cpsdvsr[7:1] == 7'd0) ? 7'd1 : cfg_cpsdvsr[7:1];
   assign w_half    = 16'(w_presc) * (16'(cfg_scr) + 16'd1);

   // ---------------- Edge scheduling ----------------
   assign w_tick        = ((r_state == S_SHIFT) || (r_state == S_GAP)) &&
                          (r_hcnt == r_half - 16'd1);
   assign w_last_edge   = (r_state == S_SHIFT) && w_tick &&
                          (r_edge == {r_nbits, 1'b0} - (NW+1)'(1));
   // Even edge index = leading edge of a bit. SPH=0 samples on it and
   // shifts on the trailing edge; SPH=1 does the opposite.
   assign w_shift_edge  = (r_state == S_SHIFT) && w_tick && (r_edge[0] != r_sph);
   assign w_sample_edge = (r_state == S_SHIFT) && w_tick && (r_edge[0] == r_sph);
   assign w_rx_bit      = r_lbm ? r_txd : ssp_rxd;

   // ---------------- FSM ----------------
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_gap_done = 1'b0;
      case (r_state)
         S_IDLE:  if (cfg_sse && !w_tx_empty) w_next = S_LOAD;
         S_LOAD: begin
            w_load = 1'b1;
            w_next = S_SHIFT;
         end
         S_SHIFT: if (w_last_edge) w_next = S_GAP;
         S_GAP: begin
            if (w_tick) begin
               w_gap_done = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- FIFO pointers and counts ----------------
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
         if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
            2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
            default: ;
         endcase
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
            2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
            default: ;
         endcase
      end
   end

   // ---------------- Serial control and outputs ----------------
   always_ff @(posedge p_clk or negedge p_resetn) begin
      if (!p_resetn) begin
         r_hcnt  <= '0;
         r_edge  <= '0;
         r_sclk  <= 1'b0;
         r_fss_n <= 1'b1;
         r_txd   <= 1'b0;
         r_bsy   <= 1'b0;
         r_nbits <= NW'(4);
         r_spo   <= 1'b0;
         r_sph   <= 1'b0;
         r_lbm   <= 1'b0;
         r_half  <= 16'd1;
      end else begin
         r_bsy <= (r_state != S_IDLE) | (cfg_sse & ~w_tx_empty);
         case (r_state)
            S_IDLE: begin
               r_sclk  <= cfg_spo;
               r_fss_n <= 1'b1;
            end
            S_LOAD: begin
               r_nbits <= w_nbits;
               r_spo   <= cfg_spo;
               r_sph   <= cfg_sph;
               r_lbm   <= cfg_lbm;
               r_half  <= w_half;
               r_hcnt  <= '0;
               r_edge  <= '0;
               r_sclk  <= cfg_spo;
               r_fss_n <= 1'b0;
               r_txd   <= w_aligned[FRAME_W-1];
            end
            S_SHIFT: begin
               if (w_tick) begin
                  r_hcnt <= '0;
                  r_edge <= r_edge + (NW+1)'(1);
                  r_sclk <= ~r_sclk;
                  if (w_shift_edge) r_txd   <= r_tx[FRAME_W-1];
                  if (w_last_edge)  r_fss_n <= 1'b1;
               end else begin
                  r_hcnt <= r_hcnt + 16'd1;
               end
            end
            S_GAP: begin
               r_sclk <= r_spo;
               r_hcnt <= w_tick ? 16'd0 : r_hcnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- Data storage and shift registers ----------------
   always_ff @(posedge p_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_wr_data;
      if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx;
      if (r_state == S_LOAD) begin
         // r_tx[MSB] is always the next bit to drive. With SPH=0 bit N-1 is
         // already on txd after LOAD, so the queue starts one bit further on.
         r_tx <= cfg_sph ? w_aligned : (w_aligned << 1);
         r_rx <= '0;
      end else begin
         if (w_shift_edge)  r_tx <= r_tx << 1;
         // Cleared at LOAD and shifted exactly N times, so bits above N stay
         // zero and the word is already zero-extended.
         if (w_sample_edge) r_rx <= {r_rx[FRAME_W-2:0], w_rx_bit};
      end
   end

   assign ssp_clk_out       = r_sclk;
   assign ssp_fss_n         = r_fss_n;
   assign ssp_txd           = r_txd;
   assign spi_bsy           = r_bsy;
   assign spi_tx_fifo_empty = w_tx_empty;
   assign spi_tx_fifo_full  = w_tx_full;
   assign spi_rx_fifo_empty = w_rx_empty;
   assign spi_rx_fifo_full  = w_rx_full;

endmodule

// File: tb/tb_ssi_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_ssi_serial_engine
//
// Directed bench for ssi_serial_engine: reset state, 8-bit loopback at the
// fastest SCLK, a divided SPH=1/SPO=1 16-bit frame against an external
// slave model, TX FIFO full, RX FIFO overflow and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_ssi_serial_engine;

   logic        p_clk = 1'b0;
   logic        p_resetn;
   logic [3:0]  cfg_dss;
   logic        cfg_spo, cfg_sph, cfg_sse, cfg_lbm;
   logic [7:0]  cfg_scr, cfg_cpsdvsr;
   logic        tx_wr_en, rx_rd_en;
   logic [15:0] tx_wr_data, rx_rd_data;
   logic        ssp_clk_out, ssp_fss_n, ssp_txd, ssp_rxd;
   logic        spi_bsy, spi_tx_fifo_empty, spi_tx_fifo_full;
   logic        spi_rx_fifo_empty, spi_rx_fifo_full;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 p_clk = ~p_clk;

   ssi_serial_engine #(.FIFO_DEPTH(8), .PTR_W(3), .FRAME_W(16)) u_dut (
      .p_clk             (p_clk),
      .p_resetn          (p_resetn),
      .cfg_dss           (cfg_dss),
      .cfg_spo           (cfg_spo),
      .cfg_sph           (cfg_sph),
      .cfg_scr           (cfg_scr),
      .cfg_cpsdvsr       (cfg_cpsdvsr),
      .cfg_sse           (cfg_sse),
      .cfg_lbm           (cfg_lbm),
      .tx_wr_en          (tx_wr_en),
      .tx_wr_data        (tx_wr_data),
      .rx_rd_en          (rx_rd_en),
      .rx_rd_data        (rx_rd_data),
      .ssp_clk_out       (ssp_clk_out),
      .ssp_fss_n         (ssp_fss_n),
      .ssp_txd           (ssp_txd),
      .ssp_rxd           (ssp_rxd),
      .spi_bsy           (spi_bsy),
      .spi_tx_fifo_empty (spi_tx_fifo_empty),
      .spi_tx_fifo_full  (spi_tx_fifo_full),
      .spi_rx_fifo_empty (spi_rx_fifo_empty),
      .spi_rx_fifo_full  (spi_rx_fifo_full)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample and drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      tx_wr_data = d;
      tx_wr_en   = 1'b1;
      tick();
      tx_wr_en   = 1'b0;
   endtask

   task automatic pop();
      rx_rd_en = 1'b1;
      tick();
      rx_rd_en = 1'b0;
   endtask

   task automatic wait_rx(input string tag, input int budget);
      int n = 0;
      while (spi_rx_fifo_empty && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(!spi_rx_fifo_empty), 1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while ((spi_bsy || !spi_tx_fifo_empty) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(spi_bsy), 0);
   endtask

   task automatic wait_fss_low(input string tag, input int budget);
      int n = 0;
      while (ssp_fss_n && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(ssp_fss_n), 0);
   endtask

   initial begin
      logic [7:0]  bits8;
      logic [15:0] txw, rxw;
      logic        prev, prevf, done, seen_low;
      int          tog, nfall, last, cyc, nf, extra;

      // ---------------- Reset then idle ----------------
      p_resetn = 1'b0;
      cfg_dss = 4'd7; cfg_spo = 1'b0; cfg_sph = 1'b0; cfg_scr = 8'd0;
      cfg_cpsdvsr = 8'd2; cfg_sse = 1'b0; cfg_lbm = 1'b0;
      tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; ssp_rxd = 1'b0;
      tick(); tick(); tick();
      chk("rst_sclk",     32'(ssp_clk_out), 0);
      chk("rst_fss_n",    32'(ssp_fss_n), 1);
      chk("rst_txd",      32'(ssp_txd), 0);
      chk("rst_bsy",      32'(spi_bsy), 0);
      chk("rst_tx_empty", 32'(spi_tx_fifo_empty), 1);
      chk("rst_tx_full",  32'(spi_tx_fifo_full), 0);
      chk("rst_rx_empty", 32'(spi_rx_fifo_empty), 1);
      chk("rst_rx_full",  32'(spi_rx_fifo_full), 0);
      chk("rst_rx_data",  32'(rx_rd_data), 0);
      p_resetn = 1'b1;
      cfg_spo = 1'b1;
      tick(); tick();
      chk("idle_sclk_spo1", 32'(ssp_clk_out), 1);
      cfg_spo = 1'b0;
      tick(); tick();
      chk("idle_sclk_spo0", 32'(ssp_clk_out), 0);

      // ---------------- Loopback 8-bit at p_clk/2 ----------------
      cfg_lbm = 1'b1; cfg_sse = 1'b1;
      tick();
      push(16'h00A5);                          // push lands on edge k
      chk("lb_fss_k0", 32'(ssp_fss_n), 1);
      tick();
      chk("lb_fss_k1", 32'(ssp_fss_n), 1);
      tick();
      chk("lb_fss_k2", 32'(ssp_fss_n), 0);
      chk("lb_bsy",    32'(spi_bsy), 1);
      bits8 = 8'hA5;
      tog   = 0;
      prev  = ssp_clk_out;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lb_txd_bit%0d", i), 32'(ssp_txd), 32'(bits8[7-i]));
         for (int j = 0; j < 2; j++) begin
            tick();
            if (ssp_clk_out !== prev) tog++;
            prev = ssp_clk_out;
         end
      end
      chk("lb_sclk_edges", 32'(tog), 16);
      chk("lb_sclk_idle",  32'(ssp_clk_out), 0);
      chk("lb_fss_end",    32'(ssp_fss_n), 1);
      wait_rx("lb_rx_wait", 20);
      chk("lb_rx_data", 32'(rx_rd_data), 32'h00A5);
      wait_idle("lb_bsy_fall", 20);
      pop();
      chk("lb_rx_empty_after_pop", 32'(spi_rx_fifo_empty), 1);
      chk("lb_rx_data_empty",      32'(rx_rd_data), 0);

      // ---------------- Divider and phase: H=6, SPH=1, SPO=1 ----------------
      cfg_cpsdvsr = 8'd4; cfg_scr = 8'd2; cfg_sph = 1'b1; cfg_spo = 1'b1;
      cfg_dss = 4'd15; cfg_lbm = 1'b0;
      tick(); tick();
      chk("ph_idle_high", 32'(ssp_clk_out), 1);
      txw = 16'hC3A5;
      rxw = 16'h3C5A;
      push(txw);
      nfall = 0; last = 0; cyc = 0; seen_low = 1'b0; done = 1'b0;
      prev  = ssp_clk_out;
      while (!done && cyc < 1000) begin
         tick();
         cyc++;
         if (!ssp_fss_n) seen_low = 1'b1;
         // Leading edge of each bit: master launches txd, slave launches rxd.
         if (prev && !ssp_clk_out) begin
            if (nfall > 0) chk("ph_period", 32'(cyc - last), 12);
            if (nfall < 16) begin
               chk($sformatf("ph_txd_bit%0d", nfall), 32'(ssp_txd), 32'(txw[15-nfall]));
               ssp_rxd = rxw[15-nfall];
            end
            last = cyc;
            nfall++;
         end
         prev = ssp_clk_out;
         if (seen_low && ssp_fss_n) done = 1'b1;
      end
      chk("ph_frame_done", 32'(done), 1);
      chk("ph_lead_edges", 32'(nfall), 16);
      chk("ph_sclk_idle",  32'(ssp_clk_out), 1);
      wait_rx("ph_rx_wait", 40);
      chk("ph_rx_data", 32'(rx_rd_data), 32'h3C5A);
      wait_idle("ph_idle", 40);
      pop();

      // ---------------- TX FIFO full, then drain ----------------
      cfg_sse = 1'b0; cfg_lbm = 1'b1; cfg_dss = 4'd7; cfg_cpsdvsr = 8'd2;
      cfg_scr = 8'd0; cfg_sph = 1'b0; cfg_spo = 1'b0;
      tick(); tick();
      for (int w = 1; w <= 9; w++) begin
         push(16'(w));
         if (w == 7) chk("txf_not_full7", 32'(spi_tx_fifo_full), 0);
         if (w == 8) chk("txf_full8",     32'(spi_tx_fifo_full), 1);
      end
      chk("txf_full9",    32'(spi_tx_fifo_full), 1);
      chk("txf_bsy_off",  32'(spi_bsy), 0);
      chk("txf_no_frame", 32'(ssp_fss_n), 1);
      cfg_sse = 1'b1;
      nf = 0; cyc = 0; prevf = 1'b1;
      tick();
      while ((nf < 8 || spi_bsy) && cyc < 1000) begin
         tick();
         cyc++;
         if (prevf && !ssp_fss_n) nf++;
         prevf = ssp_fss_n;
      end
      chk("txf_frames",   32'(nf), 8);
      chk("txf_tx_empty", 32'(spi_tx_fifo_empty), 1);
      chk("txf_rx_full",  32'(spi_rx_fifo_full), 1);
      extra = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (!ssp_fss_n) extra++;
      end
      chk("txf_no_ninth", 32'(extra), 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("txf_pop%0d", i), 32'(rx_rd_data), 32'(i + 1));
         pop();
      end
      chk("txf_rx_empty", 32'(spi_rx_fifo_empty), 1);

      // ---------------- RX overflow: 9 frames, no pops ----------------
      for (int w = 0; w < 9; w++) push(16'(16'h11 + w));
      wait_idle("rxo_idle", 1000);
      chk("rxo_rx_full", 32'(spi_rx_fifo_full), 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rxo_pop%0d", i), 32'(rx_rd_data), 32'(16'h11 + i));
         pop();
      end
      chk("rxo_rx_empty", 32'(spi_rx_fifo_empty), 1);

      // ---------------- Reset in mid-frame ----------------
      cfg_cpsdvsr = 8'd4; cfg_scr = 8'd0;       // H = 2
      tick();
      push(16'h005A);
      wait_fss_low("mr_fss_fall", 10);
      for (int c = 0; c < 13; c++) tick();      // inside bit 3
      chk("mr_in_frame", 32'(ssp_fss_n), 0);
      p_resetn = 1'b0;
      #2;
      chk("mr_fss_n",     32'(ssp_fss_n), 1);
      chk("mr_sclk",      32'(ssp_clk_out), 0);
      chk("mr_txd",       32'(ssp_txd), 0);
      chk("mr_bsy",       32'(spi_bsy), 0);
      chk("mr_rx_empty",  32'(spi_rx_fifo_empty), 1);
      chk("mr_tx_empty",  32'(spi_tx_fifo_empty), 1);
      chk("mr_rx_data",   32'(rx_rd_data), 0);
      tick(); tick();
      p_resetn = 1'b1;
      extra = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (!ssp_fss_n || spi_bsy) extra++;
      end
      chk("mr_no_restart",   32'(extra), 0);
      chk("mr_rx_empty_end", 32'(spi_rx_fifo_empty), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
